// File: rtl/verificador_tiro.sv
// Shot verifier for a two-player battleship board.
// Each player owns a 9x9 piece map and a hit map. Pieces are placed while IDLE.
// A rising edge on ready starts one shot check, and the verdict holds until ready drops.
module verificador_tiro (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       place_valid,
    input  logic       place_player,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    input  logic       ready,
    input  logic       jogador,
    input  logic [3:0] coord_tiroX,
    input  logic [3:0] coord_tiroY,
    output logic       acertou_tiro,
    output logic [3:0] qtd_P1,
    output logic [3:0] qtd_P2,
    output logic       done,
    output logic       invalid
);

    typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

    state_t            state, state_nx;
    logic              ready_q;
    logic [3:0]        shot_x, shot_y;
    logic              shot_p;
    logic [1:0][80:0]  piece_map;
    logic [1:0][80:0]  hit_map;
    logic [1:0][3:0]   qtd;

    logic              rise;
    logic              shot_ok, shot_hit, tgt;
    logic [6:0]        shot_idx, place_idx;
    logic              place_ok;
    logic              do_latch, do_place, do_check, do_release;

    assign qtd_P1 = qtd[0];
    assign qtd_P2 = qtd[1];

    function automatic logic in_range(input logic [3:0] v);
        return (v >= 4'd1) && (v <= 4'd9);
    endfunction

    // Linear cell index (y-1)*9 + (x-1); only meaningful for in-range coordinates
    function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        logic [6:0] yy, xx;
        yy = {3'b000, y} - 7'd1;
        xx = {3'b000, x} - 7'd1;
        return 7'(yy * 7'd9) + xx;
    endfunction

    // Shot and placement qualification. Player 0 shoots board 1 and player 1 shoots board 0.
    always_comb begin
        rise      = ready & ~ready_q;
        tgt       = ~shot_p;
        shot_ok   = in_range(shot_x) && in_range(shot_y);
        shot_idx  = cell_idx(shot_x, shot_y);
        shot_hit  = 1'b0;
        if (shot_ok)
            shot_hit = piece_map[tgt][shot_idx] & ~hit_map[tgt][shot_idx];
        place_idx = cell_idx(place_x, place_y);
        place_ok  = 1'b0;
        if (place_valid && in_range(place_x) && in_range(place_y))
            place_ok = ~piece_map[place_player][place_idx] && (qtd[place_player] != 4'd15);
    end

    // Next-state logic and one-cycle action strobes. A shot edge takes priority over a placement.
    always_comb begin
        state_nx   = state;
        do_latch   = 1'b0;
        do_place   = 1'b0;
        do_check   = 1'b0;
        do_release = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = CHECK;
                    do_latch = 1'b1;
                end else if (place_ok) begin
                    do_place = 1'b1;
                end
            end
            CHECK: begin
                state_nx = HOLD;
                do_check = 1'b1;
            end
            HOLD: begin
                if (!ready) begin
                    state_nx   = IDLE;
                    do_release = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register. The FSM is frozen while enable is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else if (enable)
            state <= state_nx;
    end

    // Datapath: maps, counters, latched shot and registered verdict outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q      <= 1'b0;
            shot_x       <= '0;
            shot_y       <= '0;
            shot_p       <= 1'b0;
            piece_map    <= '0;
            hit_map      <= '0;
            qtd          <= '0;
            acertou_tiro <= 1'b0;
            done         <= 1'b0;
            invalid      <= 1'b0;
        end else if (enable) begin
            ready_q <= ready;
            done    <= do_check;
            invalid <= do_check & ~shot_ok;
            if (do_latch) begin
                shot_x <= coord_tiroX;
                shot_y <= coord_tiroY;
                shot_p <= jogador;
            end
            if (do_place) begin
                piece_map[place_player][place_idx] <= 1'b1;
                qtd[place_player]                  <= qtd[place_player] + 4'd1;
            end
            if (do_check) begin
                acertou_tiro <= shot_hit;
                if (shot_hit) begin
                    hit_map[tgt][shot_idx] <= 1'b1;
                    if (qtd[tgt] != 4'd0)
                        qtd[tgt] <= qtd[tgt] - 4'd1;
                end
            end
            if (do_release)
                acertou_tiro <= 1'b0;
        end
    end

endmodule
